// File: rtl/bubsys_rom_loader_if.sv
// SDRAM word-write port between the ROM loader and the SDRAM controller.
// Level req, one-cycle ack; addr/wdata/be are held while req is high.
interface bubsys_rom_loader_if #(
  parameter int ADDR_W = 24
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wdata;
  logic [1:0]        be;
  logic              ack;

  modport master (
    output req,
    output addr,
    output wdata,
    output be,
    input  ack
  );

  modport slave (
    input  req,
    input  addr,
    input  wdata,
    input  be,
    output ack
  );
endinterface

// File: rtl/bubsys_rom_loader.sv
// HPS ioctl ROM download -> SDRAM 16-bit word writes, with core reset hold.
// Optional BUBSYS_LOADER_CHECKSUM_EN adds o_CHECKSUM (byte sum of the image).
module bubsys_rom_loader #(
  parameter logic [15:0]       ROM_INDEX   = 16'd0,
  parameter int                ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [26:0]       ROM_BYTES   = 27'h0200000,
  parameter logic [15:0]       HOLD_CYCLES = 16'd1024
) (
  input  logic                i_EMU_MCLK,
  input  logic                i_EMU_INITRST,
  input  logic [15:0]         i_IOCTL_INDEX,
  input  logic                i_IOCTL_DOWNLOAD,
  input  logic [26:0]         i_IOCTL_ADDR,
  input  logic [7:0]          i_IOCTL_DATA,
  input  logic                i_IOCTL_WR,
  output logic                o_IOCTL_WAIT,
  bubsys_rom_loader_if.master sdram,
  output logic                o_CORE_RST,
  output logic                o_DL_DONE,
  output logic                o_ERR
`ifdef BUBSYS_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]         o_CHECKSUM
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    FLUSH,
    HOLD
  } state_t;

  state_t      state;
  logic        dl_q;
  logic        pend_valid;
  logic [25:0] pend_word;
  logic [7:0]  pend_byte;
  logic        rel;
  logic [15:0] cnt;

  logic              idx_hit;
  logic              wr_hit;
  logic              start;
  logic              in_range;
  logic [25:0]       word;
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_match;

  assign idx_hit    = i_IOCTL_INDEX == ROM_INDEX;
  assign wr_hit     = i_IOCTL_WR & i_IOCTL_DOWNLOAD & idx_hit;
  assign start      = i_IOCTL_DOWNLOAD & ~dl_q & idx_hit;
  assign in_range   = i_IOCTL_ADDR < ROM_BYTES;
  assign word       = i_IOCTL_ADDR[26:1];
  assign word_addr  = BASE_ADDR + ADDR_W'(word);
  assign pend_addr  = BASE_ADDR + ADDR_W'(pend_word);
  assign pend_match = pend_valid & (pend_word == word);

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      state        <= IDLE;
      dl_q         <= 1'b0;
      pend_valid   <= 1'b0;
      pend_word    <= '0;
      pend_byte    <= '0;
      rel          <= 1'b0;
      cnt          <= '0;
      o_IOCTL_WAIT <= 1'b0;
      sdram.req    <= 1'b0;
      sdram.addr   <= '0;
      sdram.wdata  <= '0;
      sdram.be     <= '0;
      o_CORE_RST   <= 1'b1;
      o_DL_DONE    <= 1'b0;
      o_ERR        <= 1'b0;
`ifdef BUBSYS_LOADER_CHECKSUM_EN
      o_CHECKSUM   <= '0;
`endif
    end else begin
      dl_q <= i_IOCTL_DOWNLOAD;
      // WAIT trails the ack by one cycle
      if (rel) begin
        o_IOCTL_WAIT <= 1'b0;
        rel          <= 1'b0;
      end
      if (start && (state == IDLE || state == HOLD)) begin
        state      <= COLLECT;
        pend_valid <= 1'b0;
        o_CORE_RST <= 1'b1;
        o_DL_DONE  <= 1'b0;
        o_ERR      <= 1'b0;
`ifdef BUBSYS_LOADER_CHECKSUM_EN
        o_CHECKSUM <= '0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
          end
          HOLD: begin
            if (cnt == 16'd0) begin
              o_CORE_RST <= 1'b0;
              o_DL_DONE  <= 1'b1;
              state      <= IDLE;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          COLLECT: begin
            if (wr_hit) begin
              if (o_IOCTL_WAIT || !in_range) begin
                o_ERR <= 1'b1;
              end else begin
`ifdef BUBSYS_LOADER_CHECKSUM_EN
                o_CHECKSUM <= o_CHECKSUM + {8'h00, i_IOCTL_DATA};
`endif
                if (!i_IOCTL_ADDR[0]) begin
                  pend_byte  <= i_IOCTL_DATA;
                  pend_word  <= word;
                  pend_valid <= 1'b1;
                  // an orphaned even byte goes out alone
                  if (pend_valid) begin
                    sdram.addr   <= pend_addr;
                    sdram.wdata  <= {8'h00, pend_byte};
                    sdram.be     <= 2'b01;
                    sdram.req    <= 1'b1;
                    o_IOCTL_WAIT <= 1'b1;
                    state        <= FLUSH;
                  end
                end else if (pend_match) begin
                  sdram.addr   <= word_addr;
                  sdram.wdata  <= {i_IOCTL_DATA, pend_byte};
                  sdram.be     <= 2'b11;
                  sdram.req    <= 1'b1;
                  o_IOCTL_WAIT <= 1'b1;
                  pend_valid   <= 1'b0;
                  state        <= WRITE;
                end else begin
                  sdram.addr   <= word_addr;
                  sdram.wdata  <= {i_IOCTL_DATA, 8'h00};
                  sdram.be     <= 2'b10;
                  sdram.req    <= 1'b1;
                  o_IOCTL_WAIT <= 1'b1;
                  state        <= WRITE;
                end
              end
            end else if (!i_IOCTL_DOWNLOAD) begin
              if (pend_valid) begin
                sdram.addr   <= pend_addr;
                sdram.wdata  <= {8'h00, pend_byte};
                sdram.be     <= 2'b01;
                sdram.req    <= 1'b1;
                o_IOCTL_WAIT <= 1'b1;
                pend_valid   <= 1'b0;
                state        <= FLUSH;
              end else if (!sdram.req) begin
                cnt   <= HOLD_CYCLES;
                state <= HOLD;
              end
            end
          end
          WRITE, FLUSH: begin
            if (wr_hit) begin
              o_ERR <= 1'b1;
            end
            if (sdram.ack) begin
              sdram.req <= 1'b0;
              rel       <= 1'b1;
              state     <= COLLECT;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bubsys_rom_loader.sv
// Directed bench for bubsys_rom_loader: packing table plus
// hand-written fall/hold/slow-ack/filter/reset sequences.
module tb_bubsys_rom_loader;
  localparam int          AW   = 24;
  localparam logic [23:0] BASE = 24'h000100;
  localparam logic [26:0] RB   = 27'h200;
  localparam int          HC   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] idx = 16'd0;
  logic        dl  = 1'b0;
  logic [26:0] ioa = '0;
  logic [7:0]  iod = '0;
  logic        iow = 1'b0;
  logic        wt;
  logic        core_rst;
  logic        done;
  logic        err;
`ifdef BUBSYS_LOADER_CHECKSUM_EN
  logic [15:0] csum;
`endif

  always #5 clk = ~clk;

  bubsys_rom_loader_if #(.ADDR_W(AW)) sd ();

  bubsys_rom_loader #(
    .ROM_INDEX  (16'd0),
    .ADDR_W     (AW),
    .BASE_ADDR  (BASE),
    .ROM_BYTES  (RB),
    .HOLD_CYCLES(16'(HC))
  ) dut (
    .i_EMU_MCLK      (clk),
    .i_EMU_INITRST   (rst),
    .i_IOCTL_INDEX   (idx),
    .i_IOCTL_DOWNLOAD(dl),
    .i_IOCTL_ADDR    (ioa),
    .i_IOCTL_DATA    (iod),
    .i_IOCTL_WR      (iow),
    .o_IOCTL_WAIT    (wt),
    .sdram           (sd.master),
    .o_CORE_RST      (core_rst),
    .o_DL_DONE       (done),
    .o_ERR           (err)
`ifdef BUBSYS_LOADER_CHECKSUM_EN
    ,
    .o_CHECKSUM      (csum)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [26:0] a;
    logic [7:0]  d;
    logic        wr;
    logic [23:0] ea;
    logic [15:0] ed;
    logic [1:0]  eb;
    logic        er;
    int          dly;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
    ioa = a;
    iod = d;
    iow = 1'b1;
    tick();
    iow = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [23:0] ea,
                              input logic [15:0] ed, input logic [1:0] eb);
    chk({tag, " req"}, sd.req, 1'b1);
    chk({tag, " wait"}, wt, 1'b1);
    chk({tag, " addr"}, sd.addr, ea);
    chk({tag, " wdata"}, sd.wdata, ed);
    chk({tag, " be"}, sd.be, eb);
  endtask

  task automatic ack_write(input string tag, input int dly,
                           input logic [23:0] ea, input logic [15:0] ed,
                           input logic [1:0] eb);
    int bad;
    bad = 0;
    for (int k = 0; k < dly; k++) begin
      tick();
      if (sd.req !== 1'b1 || wt !== 1'b1 || sd.addr !== ea ||
          sd.wdata !== ed || sd.be !== eb)
        bad++;
    end
    if (dly > 0) chk({tag, " hold"}, bad, 0);
    sd.ack = 1'b1;
    tick();
    sd.ack = 1'b0;
    chk({tag, " req after ack"}, sd.req, 1'b0);
    chk({tag, " wait after ack"}, wt, 1'b1);
    tick();
    chk({tag, " wait release"}, wt, 1'b0);
  endtask

  task automatic wait_hold(input string tag);
    repeat (HC) tick();
    chk({tag, " done early"}, done, 1'b0);
    chk({tag, " core_rst held"}, core_rst, 1'b1);
    tick();
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " core_rst released"}, core_rst, 1'b0);
  endtask

  initial begin
    int bad;
    sd.ack = 1'b0;

    tv[0] = '{27'h000, 8'h12, 1'b0, 24'h000, 16'h0000, 2'b00, 1'b0, 0};
    tv[1] = '{27'h001, 8'h34, 1'b1, 24'h100, 16'h3412, 2'b11, 1'b0, 1};
    tv[2] = '{27'h005, 8'hAB, 1'b1, 24'h102, 16'hAB00, 2'b10, 1'b0, 0};
    tv[3] = '{27'h006, 8'h56, 1'b0, 24'h000, 16'h0000, 2'b00, 1'b0, 0};
    tv[4] = '{27'h008, 8'h78, 1'b1, 24'h103, 16'h0056, 2'b01, 1'b0, 2};
    tv[5] = '{27'h009, 8'h9A, 1'b1, 24'h104, 16'h9A78, 2'b11, 1'b0, 0};
    tv[6] = '{27'h1FF, 8'hC3, 1'b1, 24'h1FF, 16'hC300, 2'b10, 1'b0, 1};
    tv[7] = '{27'h200, 8'h11, 1'b0, 24'h000, 16'h0000, 2'b00, 1'b1, 0};
    tv[8] = '{27'h00A, 8'h22, 1'b0, 24'h000, 16'h0000, 2'b00, 1'b1, 0};
    tv[9] = '{27'h00B, 8'h33, 1'b1, 24'h105, 16'h3322, 2'b11, 1'b1, 0};

    // reset state
    tick();
    tick();
    chk("rst wait", wt, 1'b0);
    chk("rst req", sd.req, 1'b0);
    chk("rst addr", sd.addr, 24'h0);
    chk("rst wdata", sd.wdata, 16'h0);
    chk("rst be", sd.be, 2'b00);
    chk("rst core_rst", core_rst, 1'b1);
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    #2 rst = 1'b0;

    // packing table
    dl = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      send_byte(tv[i].a, tv[i].d);
      chk({t, " err"}, err, tv[i].er);
      chk({t, " core_rst"}, core_rst, 1'b1);
      if (tv[i].wr) begin
        expect_write(t, tv[i].ea, tv[i].ed, tv[i].eb);
        ack_write(t, tv[i].dly, tv[i].ea, tv[i].ed, tv[i].eb);
      end else begin
        chk({t, " no req"}, sd.req, 1'b0);
        chk({t, " no wait"}, wt, 1'b0);
      end
    end
    dl = 1'b0;
    tick();
    chk("A req", sd.req, 1'b0);
    wait_hold("A");
    chk("A err sticky", err, 1'b1);

    // trailing even byte flushed on fall
    dl = 1'b1;
    tick();
    chk("B err cleared", err, 1'b0);
    chk("B done cleared", done, 1'b0);
    chk("B core_rst set", core_rst, 1'b1);
    send_byte(27'h0, 8'h01);
    send_byte(27'h1, 8'h02);
    expect_write("B pair", 24'h100, 16'h0201, 2'b11);
    ack_write("B pair", 0, 24'h100, 16'h0201, 2'b11);
    send_byte(27'h2, 8'h03);
    chk("B pend no req", sd.req, 1'b0);
    dl = 1'b0;
    tick();
    expect_write("B flush", 24'h101, 16'h0003, 2'b01);
    chk("B flush core_rst", core_rst, 1'b1);
    ack_write("B flush", 0, 24'h101, 16'h0003, 2'b01);
    wait_hold("B");

    // slow ack with a strobe injected mid-wait
    dl = 1'b1;
    tick();
    send_byte(27'h3, 8'h5A);
    expect_write("C", 24'h101, 16'h5A00, 2'b10);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin
        ioa = 27'h4;
        iod = 8'h77;
        iow = 1'b1;
      end
      tick();
      iow = 1'b0;
      if (sd.req !== 1'b1 || wt !== 1'b1 || sd.addr !== 24'h101 ||
          sd.wdata !== 16'h5A00 || sd.be !== 2'b10)
        bad++;
    end
    chk("C hold 20", bad, 0);
    chk("C err on violation", err, 1'b1);
    ack_write("C", 0, 24'h101, 16'h5A00, 2'b10);
    dl = 1'b0;
    tick();
    chk("C dropped no flush", sd.req, 1'b0);
    wait_hold("C");

    // other index is ignored
    idx = 16'd1;
    dl  = 1'b1;
    tick();
    send_byte(27'h0, 8'hAA);
    send_byte(27'h1, 8'hBB);
    chk("D no req", sd.req, 1'b0);
    chk("D no wait", wt, 1'b0);
    chk("D done kept", done, 1'b1);
    chk("D core_rst kept", core_rst, 1'b0);
    chk("D err kept", err, 1'b1);
    dl = 1'b0;
    tick();
    idx = 16'd0;
    tick();

    // spurious ack, then hold aborted by a new download
    dl = 1'b1;
    tick();
    chk("E err cleared", err, 1'b0);
    sd.ack = 1'b1;
    tick();
    sd.ack = 1'b0;
    chk("E spurious req", sd.req, 1'b0);
    chk("E spurious wait", wt, 1'b0);
    dl = 1'b0;
    tick();
    repeat (3) tick();
    dl = 1'b1;
    tick();
    chk("E abort core_rst", core_rst, 1'b1);
    chk("E abort done", done, 1'b0);
    send_byte(27'h0, 8'h44);
    send_byte(27'h1, 8'h55);
    expect_write("E", 24'h100, 16'h5544, 2'b11);
    ack_write("E", 0, 24'h100, 16'h5544, 2'b11);
    chk("E still in reset", core_rst, 1'b1);
    dl = 1'b0;
    tick();
    wait_hold("E");

    // reset during an outstanding write
    dl = 1'b1;
    tick();
    send_byte(27'h7, 8'h66);
    expect_write("F", 24'h103, 16'h6600, 2'b10);
    rst = 1'b1;
    dl  = 1'b0;
    tick();
    chk("F req", sd.req, 1'b0);
    chk("F wait", wt, 1'b0);
    chk("F core_rst", core_rst, 1'b1);
    chk("F done", done, 1'b0);
    chk("F addr", sd.addr, 24'h0);
    #2 rst = 1'b0;
    tick();

`ifdef BUBSYS_LOADER_CHECKSUM_EN
    begin
      logic [15:0] model;
      model = '0;
      dl = 1'b1;
      tick();
      for (int i = 0; i < 258; i++) begin
        send_byte(27'(i), 8'hFF);
        model = model + 16'h00FF;
        if (sd.req) begin
          sd.ack = 1'b1;
          tick();
          sd.ack = 1'b0;
          tick();
        end
      end
      tick();
      chk("G checksum", csum, model);
      dl = 1'b0;
      tick();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
